// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared state encoding, timing constants and timer width helper
package pulse_stretcher_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t HOLD = 2'd1;
  localparam state_t GAP  = 2'd2;
  localparam int HOLD_100MS = 12_500_000;
  localparam int GAP_50MS   = 6_250_000;
  localparam int SIM_HOLD   = 4;
  localparam int SIM_GAP    = 2;
  function automatic int timer_w(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pulse_stretcher_timer.sv
// cycle_timer: loadable down-counter, done when it reaches zero
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns 1-clock events into visible LED blinks with enforced dark gaps
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_100MS,
  parameter int GAP_CYCLES  = GAP_50MS,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);
  localparam int TW = timer_w(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t state, nxt;
  logic done, load, en, consume, full;
  logic [TW-1:0] load_val;
  always_comb begin
    consume  = state == GAP && done && (pend_cnt != '0 || pulse_in);
    nxt      = state == IDLE ? (pulse_in ? HOLD : IDLE) :
               state == HOLD ? (done ? GAP : HOLD) :
               state == GAP  ? (done ? (consume ? HOLD : IDLE) : GAP) : IDLE;
    load     = nxt != state && nxt != IDLE;
    load_val = nxt == GAP ? GAP_LD : HOLD_LD;
    en       = state != IDLE;
    full     = pend_cnt == PEND_MAX;
  end
  cycle_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .done    (done)
  );
  // a consume with a fresh pulse swaps one queued event for the new one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      led_out  <= 1'b0;
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= nxt;
      led_out  <= nxt == HOLD;
      overflow <= pulse_in && state != IDLE && !consume && full;
      if (consume) begin
        if (!pulse_in) pend_cnt <= pend_cnt - 1'b1;
      end else if (pulse_in && state != IDLE && !full) pend_cnt <= pend_cnt + 1'b1;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed per-cycle checks of {led_out,busy,pend_cnt,overflow}
module tb_pulse_stretcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_in = 1'b0;
  logic led_out, busy, overflow;
  logic [1:0] pend_cnt;
  int errors = 0;
  int checks = 0;
  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({led_out, busy, pend_cnt, overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 00000", {led_out, busy, pend_cnt, overflow});
    end
    #8 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b exp 00000", i, {led_out, busy, pend_cnt, overflow});
      end
    end
  endtask
  task automatic test_single;
    logic [4:0] e [9] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                          5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 9; i++) begin
      step(i == 0);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== e[i]) begin
        errors++;
        $display("FAIL single cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, e[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [4:0] e [20] = '{5'b11000, 5'b11010, 5'b11100, 5'b11100, 5'b01100, 5'b01100,
                           5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b01010, 5'b01010,
                           5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                           5'b00000, 5'b00000};
    for (int i = 0; i < 20; i++) begin
      step(i < 3);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== e[i]) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, e[i]);
      end
    end
  endtask
  task automatic test_overflow;
    logic [4:0] e [26] = '{5'b11000, 5'b11010, 5'b11100, 5'b11110, 5'b01111, 5'b01111,
                           5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b01100, 5'b01100,
                           5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b01010, 5'b01010,
                           5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                           5'b00000, 5'b00000};
    for (int i = 0; i < 26; i++) begin
      step(i < 6);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== e[i]) begin
        errors++;
        $display("FAIL overflow cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, e[i]);
      end
    end
  endtask
  task automatic test_reentry;
    logic [4:0] e [14] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                           5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                           5'b00000, 5'b00000};
    for (int i = 0; i < 14; i++) begin
      step(i == 0 || i == 6);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== e[i]) begin
        errors++;
        $display("FAIL reentry cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, e[i]);
      end
    end
  endtask
  task automatic test_async_reset;
    logic [4:0] pre [3] = '{5'b11000, 5'b11010, 5'b11100};
    logic [4:0] e [9] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b01000,
                          5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== pre[i]) begin
        errors++;
        $display("FAIL async_pre cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, pre[i]);
      end
    end
    pulse_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({led_out, busy, pend_cnt, overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL async_assert got %b exp 00000", {led_out, busy, pend_cnt, overflow});
    end
    #10;
    checks++;
    if ({led_out, busy, pend_cnt, overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL async_held got %b exp 00000", {led_out, busy, pend_cnt, overflow});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(i == 0);
      checks++;
      if ({led_out, busy, pend_cnt, overflow} !== e[i]) begin
        errors++;
        $display("FAIL async_after cyc %0d got %b exp %b", i, {led_out, busy, pend_cnt, overflow}, e[i]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reentry;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
